atm_keypad_entry: RTL and testbench

Upstream input stage for topLevelATM. Converts raw keypad events (one 4-bit key code per strobe) into the registered values topLevelATM consumes: Pin with password_entered, acc_number, and 6-bit transaction amounts. Provides decimal accumulation, range checking, cancel/exit generation and an inactivity timeout.

---
 rtl/atm_keypad_entry.sv | 196 +++++++++++++++++++
 tb/tb_atm_keypad_entry.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_keypad_entry.sv
// Keypad input stage for topLevelATM: decimal accumulation, range check, cancel and inactivity timeout.
// Optional macro ATM_KEY_ECHO_EN adds echo_valid/digit_count ports for a masked "*" display.
module atm_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TCNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       entry_start,
    input  logic [1:0] entry_mode,
    output logic [3:0] Pin,
    output logic       password_entered,
    output logic [3:0] acc_number,
    output logic       acc_valid,
    output logic [5:0] amount,
    output logic       amount_valid,
    output logic       exit,
    output logic       timeout,
    output logic       overflow_err,
    output logic       busy
`ifdef ATM_KEY_ECHO_EN
    ,
    output logic       echo_valid,
    output logic [2:0] digit_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;

    localparam logic [1:0]        MODE_PIN  = 2'b00;
    localparam logic [1:0]        MODE_AMT  = 2'b01;
    localparam logic [1:0]        MODE_ACC  = 2'b10;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [5:0]        acc_q, acc_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              ovf_q, ovf_d;
    logic [3:0]        pin_q, pin_d;
    logic [3:0]        accn_q, accn_d;
    logic [5:0]        amt_q, amt_d;
    logic              pw_q, pw_d;
    logic              accv_q, accv_d;
    logic              amtv_q, amtv_d;
    logic              exit_q, exit_d;
    logic              tmo_q, tmo_d;
    logic              echo_d;

    logic [9:0] cand;
    logic [9:0] limit;
    logic       start_ok;

    // Wide enough for 63*10+9, so an oversized candidate can never wrap back into range.
    assign cand     = 10'(acc_q) * 10'd10 + 10'(key_code);
    assign limit    = (mode_q == MODE_AMT) ? 10'd63 : 10'd15;
    assign start_ok = entry_start && (entry_mode != 2'b11);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        ovf_d   = ovf_q;
        pin_d   = pin_q;
        accn_d  = accn_q;
        amt_d   = amt_q;
        pw_d    = 1'b0;
        accv_d  = 1'b0;
        amtv_d  = 1'b0;
        exit_d  = 1'b0;
        tmo_d   = 1'b0;
        echo_d  = 1'b0;

        if ((state_q != S_DONE) && start_ok) begin
            state_d = S_COLLECT;
            mode_d  = entry_mode;
            acc_d   = '0;
            cnt_d   = '0;
            tcnt_d  = '0;
            ovf_d   = 1'b0;
        end else if (state_q == S_COLLECT) begin
            if (key_valid) begin
                tcnt_d = '0;
                if (key_code <= 4'd9) begin
                    if (cand <= limit) begin
                        acc_d  = cand[5:0];
                        cnt_d  = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
                        echo_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    case (key_code)
                        4'hA: begin
                            acc_d = '0;
                            cnt_d = '0;
                            ovf_d = 1'b0;
                        end
                        4'hB: begin
                            if (cnt_q != 3'd0) begin
                                state_d = S_DONE;
                                case (mode_q)
                                    MODE_PIN: begin pin_d  = acc_q[3:0]; pw_d   = 1'b1; end
                                    MODE_ACC: begin accn_d = acc_q[3:0]; accv_d = 1'b1; end
                                    default:  begin amt_d  = acc_q;      amtv_d = 1'b1; end
                                endcase
                            end
                        end
                        4'hC: begin
                            exit_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end else if (tcnt_q == TCNT_LAST) begin
                exit_d  = 1'b1;
                tmo_d   = 1'b1;
                tcnt_d  = '0;
                state_d = S_IDLE;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_PIN;
            acc_q   <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            ovf_q   <= 1'b0;
            pin_q   <= '0;
            accn_q  <= '0;
            amt_q   <= '0;
            pw_q    <= 1'b0;
            accv_q  <= 1'b0;
            amtv_q  <= 1'b0;
            exit_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            ovf_q   <= ovf_d;
            pin_q   <= pin_d;
            accn_q  <= accn_d;
            amt_q   <= amt_d;
            pw_q    <= pw_d;
            accv_q  <= accv_d;
            amtv_q  <= amtv_d;
            exit_q  <= exit_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef ATM_KEY_ECHO_EN
    logic echo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) echo_q <= 1'b0;
        else     echo_q <= echo_d;
    end

    assign echo_valid  = echo_q;
    assign digit_count = cnt_q;
`else
    logic unused_echo;
    assign unused_echo = echo_d;
`endif

    assign Pin              = pin_q;
    assign password_entered = pw_q;
    assign acc_number       = accn_q;
    assign acc_valid        = accv_q;
    assign amount           = amt_q;
    assign amount_valid     = amtv_q;
    assign exit             = exit_q;
    assign timeout          = tmo_q;
    assign overflow_err     = ovf_q;
    assign busy             = (state_q == S_COLLECT);

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Scoreboard bench for atm_keypad_entry: stimulus pushes expected strobes, a monitor pops and compares.
module tb_atm_keypad_entry;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       entry_start = 1'b0;
    logic [1:0] entry_mode = 2'b00;
    logic [3:0] Pin;
    logic       password_entered;
    logic [3:0] acc_number;
    logic       acc_valid;
    logic [5:0] amount;
    logic       amount_valid;
    logic       exit;
    logic       timeout;
    logic       overflow_err;
    logic       busy;
`ifdef ATM_KEY_ECHO_EN
    logic       echo_valid;
    logic [2:0] digit_count;
`endif

    atm_keypad_entry #(.TIMEOUT_CYCLES(TO), .TCNT_W(16)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .entry_start(entry_start), .entry_mode(entry_mode),
        .Pin(Pin), .password_entered(password_entered),
        .acc_number(acc_number), .acc_valid(acc_valid),
        .amount(amount), .amount_valid(amount_valid),
        .exit(exit), .timeout(timeout), .overflow_err(overflow_err), .busy(busy)
`ifdef ATM_KEY_ECHO_EN
        , .echo_valid(echo_valid), .digit_count(digit_count)
`endif
    );

    always #5 clk = ~clk;

    typedef enum {EV_PIN, EV_ACC, EV_AMT, EV_EXIT, EV_TMO} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       val;
    } ev_t;

    ev_t expq[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input ev_kind_e k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        expq.push_back(e);
    endtask

    // Monitor: any strobe must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (password_entered || acc_valid || amount_valid || exit)) begin
                ev_t      e;
                ev_kind_e k;
                int       v;
                int       nstb;
                nstb = int'(password_entered) + int'(acc_valid) + int'(amount_valid) + int'(exit);
                check("one_strobe", nstb == 1, nstb, 1);
                if (password_entered)  begin k = EV_PIN;  v = int'(Pin);        end
                else if (acc_valid)    begin k = EV_ACC;  v = int'(acc_number); end
                else if (amount_valid) begin k = EV_AMT;  v = int'(amount);     end
                else if (timeout)      begin k = EV_TMO;  v = 0;                end
                else                   begin k = EV_EXIT; v = 0;                end
                if (expq.size() == 0) begin
                    check("unexpected_strobe", 1'b0, int'(k), -1);
                end else begin
                    e = expq.pop_front();
                    check("strobe_kind", k == e.kind, int'(k), int'(e.kind));
                    check("strobe_value", v == e.val, v, e.val);
                end
            end
        end
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic start(input logic [1:0] m);
        @(negedge clk);
        entry_start = 1'b1;
        entry_mode  = m;
        @(negedge clk);
        entry_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("reset_values", {Pin, acc_number, amount} == 14'd0, int'({Pin, acc_number, amount}), 0);
        check("reset_flags", {password_entered, acc_valid, amount_valid, exit, timeout, overflow_err, busy} == 7'd0,
              int'({password_entered, acc_valid, amount_valid, exit, timeout, overflow_err, busy}), 0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // IDLE ignores keys
        press(4'h5);
        press(4'hB);
        check("idle_not_busy", busy == 1'b0, int'(busy), 0);

        // PIN entry 1,2,B -> 12
        start(2'b00);
        check("pin_busy", busy == 1'b1, int'(busy), 1);
        press(4'h1);
        press(4'h2);
        expect_ev(EV_PIN, 12);
        press(4'hB);
        check("pin_value", Pin == 4'd12, int'(Pin), 12);
        check("pin_done_not_busy", busy == 1'b0, int'(busy), 0);
        idle(1);
        check("pin_strobe_one_cycle", password_entered == 1'b0, int'(password_entered), 0);

        // PIN boundary: 16 rejected, 15 accepted
        start(2'b00);
        press(4'h1);
        press(4'h6);
        check("pin_ovf_set", overflow_err == 1'b1, int'(overflow_err), 1);
        press(4'h5);
        check("pin_ovf_sticky", overflow_err == 1'b1, int'(overflow_err), 1);
        expect_ev(EV_PIN, 15);
        press(4'hB);
        // entry_start while in DONE must be dropped
        entry_start = 1'b1;
        entry_mode  = 2'b00;
        @(negedge clk);
        entry_start = 1'b0;
        check("done_drops_start", busy == 1'b0, int'(busy), 0);

        // Amount: overflow keeps acc (6,4,B -> 6)
        start(2'b01);
        check("start_clears_ovf", overflow_err == 1'b0, int'(overflow_err), 0);
        press(4'h6);
        press(4'h4);
        check("amt_ovf_set", overflow_err == 1'b1, int'(overflow_err), 1);
        expect_ev(EV_AMT, 6);
        press(4'hB);
        idle(1);

        // Amount: 6,4 overflow then A,6,3,B -> 63
        start(2'b01);
        press(4'h6);
        press(4'h4);
        check("amt_ovf_set2", overflow_err == 1'b1, int'(overflow_err), 1);
        press(4'hA);
        check("clear_ovf", overflow_err == 1'b0, int'(overflow_err), 0);
        press(4'h6);
        press(4'h3);
        check("amt_63_no_ovf", overflow_err == 1'b0, int'(overflow_err), 0);
        expect_ev(EV_AMT, 63);
        press(4'hB);
        check("amt_value", amount == 6'd63, int'(amount), 63);
        idle(1);

        // Account: B with no digits ignored; 7,C -> exit only
        start(2'b10);
        press(4'hB);
        check("acc_empty_enter_busy", busy == 1'b1, int'(busy), 1);
        press(4'h7);
        expect_ev(EV_EXIT, 0);
        press(4'hC);
        check("cancel_idle", busy == 1'b0, int'(busy), 0);
        check("cancel_acc_unchanged", acc_number == 4'd0, int'(acc_number), 0);
        idle(1);

        // Account value load: 9,B
        start(2'b10);
        press(4'h9);
        expect_ev(EV_ACC, 9);
        press(4'hB);
        idle(1);

        // Timeout: exit+timeout 8 cycles after the key edge
        start(2'b01);
        expect_ev(EV_TMO, 0);
        press(4'h5);
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            check("no_early_timeout", exit == 1'b0, int'(exit), 0);
        end
        @(negedge clk);
        check("timeout_exit", exit == 1'b1 && timeout == 1'b1, int'({exit, timeout}), 3);
        check("timeout_amount_unchanged", amount == 6'd63, int'(amount), 63);
        idle(1);
        check("timeout_idle", busy == 1'b0, int'(busy), 0);

        // Ignored code D restarts the timer
        start(2'b00);
        press(4'h2);
        idle(TO - 3);
        press(4'hD);
        idle(TO - 2);
        check("d_restarts_timer", busy == 1'b1, int'(busy), 1);
        expect_ev(EV_PIN, 2);
        press(4'hB);
        idle(1);

        // Simultaneous entry_start + digit: restart, digit dropped, B ignored
        start(2'b00);
        press(4'h3);
        @(negedge clk);
        entry_start = 1'b1;
        entry_mode  = 2'b00;
        key_valid   = 1'b1;
        key_code    = 4'h9;
        @(negedge clk);
        entry_start = 1'b0;
        key_valid   = 1'b0;
        press(4'hB);
        check("restart_enter_ignored", busy == 1'b1, int'(busy), 1);
        expect_ev(EV_EXIT, 0);
        press(4'hC);
        idle(1);

        // Reset mid-COLLECT
        start(2'b01);
        press(4'h4);
        press(4'h2);
        rst = 1'b1;
        #1;
        check("rst_values", {Pin, acc_number, amount} == 14'd0, int'({Pin, acc_number, amount}), 0);
        check("rst_busy", busy == 1'b0, int'(busy), 0);
        idle(2);
        rst = 1'b0;
        press(4'hB);
        idle(3);
        check("rst_enter_ignored", amount == 6'd0 && busy == 1'b0, int'({busy, amount}), 0);

        check("queue_drained", expq.size() == 0, expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
